d24_decoder: RTL and testbench
==============================

// Module: d24_decoder
//
// PURPOSE
// - 2-to-4 line decoder with active-high enable and registered one-hot output.
// - Select a[1:0] plus enable e produce d[3:0]:
//   - enabled: exactly one bit set, at index a;
//   - disabled: all zeros.
// - Leaf block for address/chip-select decode. Output is registered, so downstream
//   logic sees glitch-free selects aligned to clk.
//
// PARAMETERS
// - SEL_W    default 2                 select width; output width is 2**SEL_W (default build 2 -> 4).
// - OUT_REG  default 1                 1 = registered output (latency 1); 0 = combinational output, reset ignored.
// - IDLE_VAL default {2**SEL_W{1'b0}}  value driven on d while disabled or in reset.
//
// PORTS
// - clk    in   1              single clock; all state updates on rising edge.
// - rst_n  in   1              synchronous, active-low reset (sampled on rising clk).
// - e      in   1              decode enable, active high.
// - a      in   SEL_W          select index, unsigned.
// - d      out  2**SEL_W       one-hot decoded output, active high; d[i]=1 selects line i.
//
// BEHAVIOUR
// - Decode function: dec(e,a) = e ? (1 << a) : IDLE_VAL.
//   - Default build truth table, {e,a} -> d:
//     - 0xx -> 0000
//     - 100 -> 0001
//     - 101 -> 0010
//     - 110 -> 0100
//     - 111 -> 1000
// - OUT_REG=1:
//   - Each rising clk: if !rst_n then d <= IDLE_VAL (0000), else d <= dec(e,a).
//   - Latency exactly 1 cycle from input sample to d. No throughput limit; a new value every cycle.
//   - Reset has priority over e/a. Reset asserted mid-operation clears d on the next edge.
//     First post-reset edge with rst_n=1 loads dec(e,a).
//   - Reset value of d: all zeros.
// - OUT_REG=0: d = dec(e,a) combinationally; clk/rst_n unused (kept for interface uniformity).
// - Invariants:
//   - popcount(d) == 1 whenever the enable that produced d was 1.
//   - popcount(d) == 0 otherwise.
// - X/Z on a while e=1: d is X (no masking required). X on e: d is X.
// - All a values 0..2**SEL_W-1 are valid; no out-of-range case exists.
// - Simultaneous change of e and a in one cycle: d reflects the pair sampled at the edge. No intermediate value.
//
// STRUCTURE
// - Package d24_pkg:
//   - localparam SEL_W_DEFAULT = 2;
//   - function automatic onehot(input logic en, input logic [SEL_W-1:0] sel), the shared decode function.
// - Sub-module d24_onehot_core: purely combinational dec(e,a), parameterised by SEL_W.
// - d24_decoder wraps d24_onehot_core with the optional output register (generate on OUT_REG) and reset mux.
// - No FSM; single register of width 2**SEL_W.
//
// TESTING
// - Reset: rst_n=0 for 2 clk with e=1, a=2'b11 -> d==4'b0000 throughout. Release -> next edge d==4'b1000.
// - Disabled sweep: e=0, a=0..3, one per cycle -> d==4'b0000 every cycle after latency.
// - Enabled sweep: e=1, a=0,1,2,3 -> d==0001,0010,0100,1000, each one cycle after the input.
// - Exhaustive {e,a}=0..7, each held 10 time units -> d matches the truth table.
//   - Check popcount(d)==e (delayed one cycle).
// - Mid-run reset: e=1, a=1 streaming, assert rst_n=0 one cycle -> d==0000 that cycle, then 0010 resumes.
// - Back-to-back toggle: e alternates 1/0 with a=2 every cycle -> d alternates 0100/0000 at 1-cycle latency.

Source files
------------

// File: rtl/d24_pkg.sv
// Shared types and decode helper for the 2-to-4 decoder slice.
// Holds the default select width and the one-hot decode function.
package d24_pkg;

    localparam int SEL_W_DEFAULT = 2;
    localparam int SEL_W = SEL_W_DEFAULT;
    localparam int OUT_W = 2 ** SEL_W;

    function automatic logic [OUT_W-1:0] onehot(
        input logic             en,
        input logic [SEL_W-1:0] sel
    );
        logic [OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return en ? v : '0;
    endfunction

endpackage

// File: rtl/d24_onehot_core.sv
// Combinational one-hot decode: d = e ? (1 << a) : IDLE_VAL.
// Ports: e (enable), a (select), d (one-hot out).
module d24_onehot_core
    import d24_pkg::*;
#(
    parameter int                  W_SEL    = SEL_W_DEFAULT,
    parameter logic [2**W_SEL-1:0] IDLE_VAL = '0
) (
    input  logic               e,
    input  logic [W_SEL-1:0]   a,
    output logic [2**W_SEL-1:0] d
);

    localparam int N = 2 ** W_SEL;

    logic [N-1:0] oh;

    generate
        if (W_SEL == SEL_W_DEFAULT) begin : g_pkg
            assign oh = onehot(1'b1, a);
        end else begin : g_gen
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign oh[i] = (a == W_SEL'(i));
            end
        end
    endgenerate

    // Ternary keeps X on e visible on d.
    assign d = e ? oh : IDLE_VAL;

endmodule

// File: rtl/d24_decoder.sv
// 2-to-4 line decoder with enable and optional output register.
// Ports: clk, rst_n (sync, active low), e, a[SEL_W-1:0], d[2**SEL_W-1:0].
module d24_decoder
    import d24_pkg::*;
#(
    parameter int                  SEL_W    = SEL_W_DEFAULT,
    parameter bit                  OUT_REG  = 1'b1,
    parameter logic [2**SEL_W-1:0] IDLE_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 e,
    input  logic [SEL_W-1:0]     a,
    output logic [2**SEL_W-1:0]  d
);

    logic [2**SEL_W-1:0] dec;

    d24_onehot_core #(
        .W_SEL    (SEL_W),
        .IDLE_VAL (IDLE_VAL)
    ) u_core (
        .e (e),
        .a (a),
        .d (dec)
    );

    generate
        if (OUT_REG) begin : g_reg
            logic [2**SEL_W-1:0] d_q;

            // Reset wins over any e/a activity.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d_q <= IDLE_VAL;
                end else begin
                    d_q <= dec;
                end
            end

            assign d = d_q;
        end else begin : g_comb
            assign d = dec;
        end
    endgenerate

endmodule

// File: tb/tb_d24_decoder.sv
// Directed self-checking bench for d24_decoder (default build).
// Drives inputs just after each edge, checks d one edge later.
module tb_d24_decoder;

    logic       clk;
    logic       rst_n;
    logic       e;
    logic [1:0] a;
    logic [3:0] d;

    int n_cmp;
    int n_bad;

    d24_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .a     (a),
        .d     (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string      tag,
        input logic [3:0] got,
        input logic [3:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    // Apply inputs, take one edge, settle.
    task automatic step(
        input logic       r,
        input logic       en,
        input logic [1:0] sel
    );
        rst_n = r;
        e     = en;
        a     = sel;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] tt [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tt = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
               4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst_n = 1'b0;
        e     = 1'b1;
        a     = 2'b11;

        step(1'b0, 1'b1, 2'b11);
        chk("rst0", d, 4'b0000);
        step(1'b0, 1'b1, 2'b11);
        chk("rst1", d, 4'b0000);
        step(1'b1, 1'b1, 2'b11);
        chk("rel", d, 4'b1000);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'(i));
            chk("dis", d, 4'b0000);
        end

        step(1'b1, 1'b1, 2'd0);
        chk("en0", d, 4'b0001);
        step(1'b1, 1'b1, 2'd1);
        chk("en1", d, 4'b0010);
        step(1'b1, 1'b1, 2'd2);
        chk("en2", d, 4'b0100);
        step(1'b1, 1'b1, 2'd3);
        chk("en3", d, 4'b1000);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step(1'b1, v[2], v[1:0]);
            chk("tt", d, tt[i]);
            chk("pop", 4'($countones(d)), {3'b000, v[2]});
        end

        step(1'b1, 1'b1, 2'd1);
        chk("mid_pre", d, 4'b0010);
        step(1'b0, 1'b1, 2'd1);
        chk("mid_rst", d, 4'b0000);
        step(1'b1, 1'b1, 2'd1);
        chk("mid_post", d, 4'b0010);
        step(1'b1, 1'b1, 2'd1);
        chk("mid_hold", d, 4'b0010);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i % 2) == 0, 2'd2);
            chk("tog", d, ((i % 2) == 0) ? 4'b0100 : 4'b0000);
        end

        step(1'b1, 1'b1, 2'd3);
        chk("sim_a", d, 4'b1000);
        step(1'b1, 1'b0, 2'd0);
        chk("sim_b", d, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
